mips_if_prefetch: RTL and testbench

Parametrised successor to the single-register MIPS instruction-fetch stage. It decouples I-cache fetch from ID consumption with a DEPTH-entry prefetch queue. It handles branch/jump redirects, including a redirect that arrives while an I-cache miss is outstanding, and presents one instruction per cycle to the ID stage. It sits between the I-cache port and MIPS_ID, replacing MIPS_IF.

---
 rtl/mips_pkg.sv | 17 +
 rtl/mips_fetch_queue.sv | 60 ++++++
 rtl/mips_if_prefetch.sv | 156 +++++++++++++++
 tb/tb_mips_if_prefetch.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the prefetching MIPS instruction-fetch stage.
package mips_pkg;

    localparam logic [31:0] NOP = 32'h0;

    typedef enum logic {
        S_RUN,
        S_DRAIN
    } if_state_t;

    // pc holds the address of the instruction plus 4, as ID expects it
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } q_entry_t;

endpackage

// File: rtl/mips_fetch_queue.sv
// Circular FIFO of fetched {pc+4, inst} pairs between I-cache and ID; flush wins over push.
module mips_fetch_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [31:0]              push_pc,
    input  logic [31:0]              push_inst,
    output logic [31:0]              head_pc,
    output logic [31:0]              head_inst,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    q_entry_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW:0]     count_reg;
    q_entry_t        push_entry;

    assign push_entry = '{pc: push_pc, inst: push_inst};

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_reg] <= push_entry;
        end
    end

    // Pointers are exactly AW bits wide, so DEPTH being a power of two lets them wrap for free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign head_pc   = mem[rd_ptr_reg].pc;
    assign head_inst = mem[rd_ptr_reg].inst;
    assign count     = count_reg;

endmodule

// File: rtl/mips_if_prefetch.sv
// MIPS instruction fetch with a DEPTH-entry prefetch queue and redirect handling across
// outstanding I-cache misses (S_DRAIN waits out the stale response before fetching the target).
module mips_if_prefetch
    import mips_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [31:0]              redirect_addr,
    output logic                     I_read,
    output logic                     I_write,
    output logic [29:0]              I_addr,
    output logic [31:0]              I_wdata,
    input  logic                     I_stall,
    input  logic [31:0]              I_rdata,
    output logic                     IF_stall,
    output logic [31:0]              ID_pc,
    output logic [31:0]              ID_inst,
    output logic                     ID_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    if_state_t    state_reg, state_next;
    logic [31:0]  fpc_reg, fpc_next;
    logic [31:0]  tgt_reg, tgt_next;
    logic [31:0]  id_pc_reg, id_pc_next;
    logic [31:0]  id_inst_reg, id_inst_next;
    logic         id_valid_reg, id_valid_next;

    logic         acc;
    logic         take_redirect;
    logic [31:0]  fpc_plus4;
    logic         q_push, q_pop, q_flush;
    logic [31:0]  head_pc, head_inst;
    logic [CW-1:0] q_count;

    mips_fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push),
        .pop       (q_pop),
        .flush     (q_flush),
        .push_pc   (fpc_plus4),
        .push_inst (I_rdata),
        .head_pc   (head_pc),
        .head_inst (head_inst),
        .count     (q_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_RUN;
            fpc_reg      <= RESET_PC;
            tgt_reg      <= '0;
            id_pc_reg    <= '0;
            id_inst_reg  <= NOP;
            id_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fpc_reg      <= fpc_next;
            tgt_reg      <= tgt_next;
            id_pc_reg    <= id_pc_next;
            id_inst_reg  <= id_inst_next;
            id_valid_reg <= id_valid_next;
        end
    end

    always_comb begin
        I_read        = (q_count < DEPTH_C) || (state_reg == S_DRAIN);
        acc           = I_read && !I_stall;
        take_redirect = redirect && !stall;
        fpc_plus4     = fpc_reg + 32'd4;

        state_next    = state_reg;
        fpc_next      = fpc_reg;
        tgt_next      = tgt_reg;
        id_pc_next    = id_pc_reg;
        id_inst_next  = id_inst_reg;
        id_valid_next = id_valid_reg;
        q_push        = 1'b0;
        q_pop         = 1'b0;
        q_flush       = 1'b0;

        case (state_reg)
            S_RUN: begin
                if (take_redirect) begin
                    q_flush       = 1'b1;
                    id_inst_next  = NOP;
                    id_valid_next = 1'b0;
                    // A miss in flight must still be consumed, so park the target until it lands
                    if (I_read && I_stall) begin
                        tgt_next   = redirect_addr;
                        state_next = S_DRAIN;
                    end else begin
                        fpc_next = redirect_addr;
                    end
                end else begin
                    if (acc) begin
                        fpc_next = fpc_plus4;
                    end
                    if (!stall && q_count == '0) begin
                        id_pc_next    = fpc_plus4;
                        id_inst_next  = acc ? I_rdata : NOP;
                        id_valid_next = acc;
                        if (!acc) begin
                            id_pc_next = id_pc_reg;
                        end
                    end else begin
                        q_push = acc;
                        if (!stall) begin
                            q_pop         = 1'b1;
                            id_pc_next    = head_pc;
                            id_inst_next  = head_inst;
                            id_valid_next = 1'b1;
                        end
                    end
                end
            end
            S_DRAIN: begin
                id_inst_next  = NOP;
                id_valid_next = 1'b0;
                if (take_redirect) begin
                    q_flush  = 1'b1;
                    tgt_next = redirect_addr;
                end
                // The stale word returning now is dropped; the newest target wins
                if (acc) begin
                    state_next = S_RUN;
                    fpc_next   = take_redirect ? redirect_addr : tgt_reg;
                end
            end
            default: begin
                state_next = S_RUN;
            end
        endcase
    end

    assign I_write  = 1'b0;
    assign I_wdata  = 32'h0;
    assign I_addr   = fpc_reg[31:2];
    assign IF_stall = I_read && I_stall;
    assign ID_pc    = id_pc_reg;
    assign ID_inst  = id_inst_reg;
    assign ID_valid = id_valid_reg;
    assign count    = q_count;

endmodule

// File: tb/tb_mips_if_prefetch.sv
// Self-checking bench: directed vector table on a DEPTH=4 instance, then random traffic on
// DEPTH=2 and DEPTH=8 instances checked against a program-order scoreboard.
module tb_mips_if_prefetch;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        bit          rst;
        bit          stl;
        bit          ist;
        bit          rdr;
        logic [31:0] raddr;
        int          e_count;
        bit          e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [29:0] e_iaddr;
        bit          e_iread;
    } vec_t;

    int n_pass = 0;
    int n_tot  = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [29:0] wa);
        return {wa[13:0], wa[29:14], 2'b01} ^ 32'h5A3C_0F00;
    endfunction

    function automatic logic [31:0] mb(input logic [31:0] a);
        logic [31:0] t;
        t = a;
        return mem_word(t[31:2]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- directed instance, DEPTH=4 ----------------
    logic        rstn_a = 1'b0, stall_a = 1'b0, ist_a = 1'b0, rdr_a = 1'b0;
    logic [31:0] raddr_a = '0;
    logic        iread_a, iwrite_a, ifst_a, idval_a;
    logic [29:0] iaddr_a;
    logic [31:0] iwdata_a, rdata_a, idpc_a, idinst_a;
    logic [2:0]  count_a;

    assign rdata_a = mem_word(iaddr_a);

    mips_if_prefetch #(.DEPTH(4), .RESET_PC(32'h0)) u4 (
        .clk(clk), .rst_n(rstn_a), .stall(stall_a), .redirect(rdr_a), .redirect_addr(raddr_a),
        .I_read(iread_a), .I_write(iwrite_a), .I_addr(iaddr_a), .I_wdata(iwdata_a),
        .I_stall(ist_a), .I_rdata(rdata_a), .IF_stall(ifst_a),
        .ID_pc(idpc_a), .ID_inst(idinst_a), .ID_valid(idval_a), .count(count_a)
    );

    // ---------------- random instances, DEPTH=2 and DEPTH=8 ----------------
    logic        rstn_r = 1'b0, stall_r = 1'b0, ist_r = 1'b0, rdr_r = 1'b0;
    logic [31:0] raddr_r = '0;
    logic        iread_r [2];
    logic        iwrite_r [2];
    logic        ifst_r [2];
    logic        idval_r [2];
    logic [29:0] iaddr_r [2];
    logic [31:0] iwdata_r [2];
    logic [31:0] rdata_r [2];
    logic [31:0] idpc_r [2];
    logic [31:0] idinst_r [2];
    logic [1:0]  count2;
    logic [3:0]  count8;

    assign rdata_r[0] = mem_word(iaddr_r[0]);
    assign rdata_r[1] = mem_word(iaddr_r[1]);

    mips_if_prefetch #(.DEPTH(2), .RESET_PC(32'h0)) u2 (
        .clk(clk), .rst_n(rstn_r), .stall(stall_r), .redirect(rdr_r), .redirect_addr(raddr_r),
        .I_read(iread_r[0]), .I_write(iwrite_r[0]), .I_addr(iaddr_r[0]), .I_wdata(iwdata_r[0]),
        .I_stall(ist_r), .I_rdata(rdata_r[0]), .IF_stall(ifst_r[0]),
        .ID_pc(idpc_r[0]), .ID_inst(idinst_r[0]), .ID_valid(idval_r[0]), .count(count2)
    );

    mips_if_prefetch #(.DEPTH(8), .RESET_PC(32'h0)) u8 (
        .clk(clk), .rst_n(rstn_r), .stall(stall_r), .redirect(rdr_r), .redirect_addr(raddr_r),
        .I_read(iread_r[1]), .I_write(iwrite_r[1]), .I_addr(iaddr_r[1]), .I_wdata(iwdata_r[1]),
        .I_stall(ist_r), .I_rdata(rdata_r[1]), .IF_stall(ifst_r[1]),
        .ID_pc(idpc_r[1]), .ID_inst(idinst_r[1]), .ID_valid(idval_r[1]), .count(count8)
    );

    // Program-order scoreboard: head of each queue is the next instruction ID must consume
    exp_t sb [2][$];
    exp_t e_tmp;
    int   deliv [2];
    bit   rand_on = 1'b0;

    always @(negedge clk) begin
        if (rand_on) begin
            for (int k = 0; k < 2; k++) begin
                if (!rstn_r) begin
                    sb[k].delete();
                    sb[k].push_back('{pc: 32'd4, inst: mb(32'h0)});
                end else if (!stall_r) begin
                    if (idval_r[k]) begin
                        if (sb[k].size() == 0) begin
                            n_tot++;
                            $display("FAIL rand D%0d extra: got pc %h expected none",
                                     (k == 0) ? 2 : 8, idpc_r[k]);
                        end else begin
                            e_tmp = sb[k].pop_front();
                            check($sformatf("rand D%0d pc", (k == 0) ? 2 : 8), idpc_r[k], e_tmp.pc);
                            check($sformatf("rand D%0d inst", (k == 0) ? 2 : 8), idinst_r[k], e_tmp.inst);
                            $display("D%0d consumed pc=%h inst=%h", (k == 0) ? 2 : 8, idpc_r[k], idinst_r[k]);
                            deliv[k]++;
                            sb[k].push_back('{pc: e_tmp.pc + 32'd4, inst: mb(e_tmp.pc)});
                        end
                    end
                    if (rdr_r) begin
                        sb[k].delete();
                        sb[k].push_back('{pc: raddr_r + 32'd4, inst: mb(raddr_r)});
                    end
                end
            end
        end
    end

    vec_t v[$];

    function automatic vec_t mk(bit rst, bit stl, bit ist, bit rdr, logic [31:0] raddr,
                                int ec, bit ev, logic [31:0] epc, logic [31:0] einst,
                                logic [29:0] eia, bit eir);
        vec_t r;
        r.rst = rst; r.stl = stl; r.ist = ist; r.rdr = rdr; r.raddr = raddr;
        r.e_count = ec; r.e_valid = ev; r.e_pc = epc; r.e_inst = einst;
        r.e_iaddr = eia; r.e_iread = eir;
        return r;
    endfunction

    initial begin
        // reset state, with I_stall high to see IF_stall follow it
        v.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 30'h0, 1));
        // free-running: one-cycle bypass latency
        for (int k = 1; k <= 6; k++)
            v.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'(4 * k), mb(32'(4 * k - 4)), 30'(k), 1));
        // reset, one run cycle, then a 6-cycle stall fills the queue
        v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 30'h0, 1));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'd4, mb(32'h0), 30'h1, 1));
        for (int k = 1; k <= 6; k++)
            v.push_back(mk(0, 1, 0, 0, 0, (k < 4) ? k : 4, 1, 32'd4, mb(32'h0),
                           30'((k < 4) ? k + 1 : 5), k < 4));
        // release: queue drains in order while refilling
        for (int k = 0; k < 5; k++)
            v.push_back(mk(0, 0, 0, 0, 0, 3, 1, 32'(8 + 4 * k), mb(32'(4 + 4 * k)), 30'(5 + k), 1));
        // redirect with count=3
        v.push_back(mk(0, 0, 0, 1, 32'h100, 0, 0, 0, 0, 30'h40, 1));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h104, mb(32'h100), 30'h41, 1));
        // redirect during a 3-cycle miss
        v.push_back(mk(0, 0, 1, 1, 32'h200, 0, 0, 0, 0, 30'h41, 1));
        v.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 30'h41, 1));
        v.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 30'h41, 1));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 30'h80, 1));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h204, mb(32'h200), 30'h81, 1));
        // second redirect while draining replaces the target
        v.push_back(mk(0, 0, 1, 1, 32'h200, 0, 0, 0, 0, 30'h81, 1));
        v.push_back(mk(0, 0, 1, 1, 32'h300, 0, 0, 0, 0, 30'h81, 1));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 30'hC0, 1));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h304, mb(32'h300), 30'hC1, 1));
        // redirect under stall is ignored
        v.push_back(mk(0, 1, 0, 0, 0, 1, 1, 32'h304, mb(32'h300), 30'hC2, 1));
        v.push_back(mk(0, 1, 1, 1, 32'h500, 1, 1, 32'h304, mb(32'h300), 30'hC2, 1));
        v.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h308, mb(32'h304), 30'hC3, 1));

        foreach (v[i]) begin
            rstn_a  = !v[i].rst;
            stall_a = v[i].stl;
            ist_a   = v[i].ist;
            rdr_a   = v[i].rdr;
            raddr_a = v[i].raddr;
            @(posedge clk);
            #1;
            $display("vec %0d: count=%0d valid=%0b pc=%h inst=%h I_addr=%h I_read=%0b",
                     i, count_a, idval_a, idpc_a, idinst_a, iaddr_a, iread_a);
            check($sformatf("v%0d count", i), 32'(count_a), 32'(v[i].e_count));
            check($sformatf("v%0d ID_valid", i), 32'(idval_a), 32'(v[i].e_valid));
            check($sformatf("v%0d ID_inst", i), idinst_a, v[i].e_inst);
            check($sformatf("v%0d I_addr", i), 32'(iaddr_a), 32'(v[i].e_iaddr));
            check($sformatf("v%0d I_read", i), 32'(iread_a), 32'(v[i].e_iread));
            check($sformatf("v%0d IF_stall", i), 32'(ifst_a), 32'(v[i].e_iread & v[i].ist));
            if (v[i].e_valid || v[i].rst)
                check($sformatf("v%0d ID_pc", i), idpc_a, v[i].e_pc);
            if (i == 0) begin
                check("I_write", 32'(iwrite_a), 32'h0);
                check("I_wdata", iwdata_a, 32'h0);
            end
        end

        // random phase on DEPTH=2 and DEPTH=8, including a reset in the middle of the run
        for (int k = 0; k < 2; k++) begin
            sb[k].delete();
            sb[k].push_back('{pc: 32'd4, inst: mb(32'h0)});
            deliv[k] = 0;
        end
        @(posedge clk);
        #1;
        rstn_r  = 1'b1;
        rand_on = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            #1;
            rstn_r  = (c != 1000);
            stall_r = ($urandom_range(0, 3) == 0);
            ist_r   = (c == 1000) ? 1'b1 : ($urandom_range(0, 9) < 3);
            rdr_r   = ($urandom_range(0, 9) == 0);
            raddr_r = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0
                                                  : {14'h0, 16'($urandom_range(0, 16'hFFFF)), 2'b00};
        end
        @(posedge clk);
        #1;
        rand_on = 1'b0;
        check("D2 deliveries>200", 32'(deliv[0] > 200), 32'h1);
        check("D8 deliveries>200", 32'(deliv[1] > 200), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
